// File: rtl/pe_dot_sched.sv
// Command-driven operand sequencer for a single 1-cycle PE, with MAC feedback and a 2-entry result FIFO.
// Defining PE_SCHED_PERF_EN adds the o_perf_busy / o_perf_stall cycle counters.
module pe_dot_sched #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ACC_WIDTH  = 32,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic [1:0]            i_cmd_mode,
    input  logic [LEN_WIDTH-1:0]  i_cmd_len,
    output logic                  o_cmd_err,
    input  logic                  i_op_valid,
    output logic                  o_op_ready,
    input  logic [DATA_WIDTH-1:0] i_op_a,
    input  logic [DATA_WIDTH-1:0] i_op_b,
    output logic                  o_pe_valid,
    output logic [1:0]            o_pe_mode,
    output logic [DATA_WIDTH-1:0] o_pe_a,
    output logic [DATA_WIDTH-1:0] o_pe_b,
    output logic [ACC_WIDTH-1:0]  o_pe_acc,
    input  logic [ACC_WIDTH-1:0]  i_pe_result,
    input  logic                  i_pe_valid_out,
    output logic                  o_res_valid,
    input  logic                  i_res_ready,
    output logic [ACC_WIDTH-1:0]  o_res_data,
    output logic                  o_res_last
`ifdef PE_SCHED_PERF_EN
    ,
    output logic [31:0]           o_perf_busy,
    output logic [31:0]           o_perf_stall
`endif
);

    localparam logic [1:0] ModeMac = 2'b00;
    localparam logic [1:0] ModeIll = 2'b11;

    typedef enum logic {StIdle, StRun} state_t;

    state_t               r_state;
    logic                 r_alive;
    logic [1:0]           r_mode;
    logic [LEN_WIDTH-1:0] r_len;
    logic [LEN_WIDTH-1:0] r_beat;
    logic                 r_pend_push;
    logic                 r_pend_last;
    logic                 r_zero_push;
    logic                 r_cmd_err;
    logic [ACC_WIDTH-1:0] r_fifo_data [2];
    logic                 r_fifo_last [2];
    logic                 r_wr_ptr;
    logic                 r_rd_ptr;
    logic [1:0]           r_count;

    logic       w_pop;
    logic       w_push;
    logic [2:0] w_occ;
    logic       w_credit;
    logic       w_cmd_zero;
    logic       w_cmd_acc;
    logic       w_mac;
    logic       w_final;
    logic       w_push_beat;
    logic       w_fire;

    // Occupancy counts in-flight pushes and nets out a same-cycle pop for full throughput.
    assign w_pop       = (r_count != 2'd0) & i_res_ready;
    assign w_push      = (i_pe_valid_out & r_pend_push) | r_zero_push;
    assign w_occ       = {1'b0, r_count} + {2'b00, r_pend_push} + {2'b00, r_zero_push}
                         - {2'b00, w_pop};
    assign w_credit    = w_occ < 3'd2;

    assign w_cmd_zero  = (i_cmd_mode == ModeMac) && (i_cmd_len == '0);
    assign o_cmd_ready = r_alive & (r_state == StIdle) & ~(w_cmd_zero & ~w_credit);
    assign w_cmd_acc   = i_cmd_valid & o_cmd_ready;

    assign w_mac       = (r_mode == ModeMac);
    assign w_final     = (r_beat == r_len - LEN_WIDTH'(1));
    assign w_push_beat = ~w_mac | w_final;
    assign o_op_ready  = (r_state == StRun) & (~w_push_beat | w_credit);
    assign w_fire      = i_op_valid & o_op_ready;

    assign o_pe_valid  = w_fire;
    assign o_pe_mode   = r_mode;
    assign o_pe_a      = w_fire ? i_op_a : '0;
    assign o_pe_b      = w_fire ? i_op_b : '0;
    assign o_pe_acc    = (w_fire & w_mac & (r_beat != '0)) ? i_pe_result : '0;
    assign o_cmd_err   = r_cmd_err;

    assign o_res_valid = (r_count != 2'd0);
    assign o_res_data  = o_res_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign o_res_last  = o_res_valid & r_fifo_last[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StIdle;
            r_alive     <= 1'b0;
            r_mode      <= 2'b00;
            r_len       <= '0;
            r_beat      <= '0;
            r_pend_push <= 1'b0;
            r_pend_last <= 1'b0;
            r_zero_push <= 1'b0;
            r_cmd_err   <= 1'b0;
        end else begin
            r_alive     <= 1'b1;
            r_cmd_err   <= 1'b0;
            r_zero_push <= 1'b0;
            r_pend_push <= w_fire & w_push_beat;
            r_pend_last <= w_fire & w_final;
            unique case (r_state)
                StIdle: begin
                    if (w_cmd_acc) begin
                        r_mode <= i_cmd_mode;
                        r_len  <= i_cmd_len;
                        r_beat <= '0;
                        if (i_cmd_mode == ModeIll) begin
                            r_cmd_err <= 1'b1;
                        end else if (i_cmd_len == '0) begin
                            r_zero_push <= (i_cmd_mode == ModeMac);
                        end else begin
                            r_state <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (w_fire) begin
                        r_beat <= r_beat + LEN_WIDTH'(1);
                        if (w_final) begin
                            r_state <= StIdle;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_fifo_data[r_wr_ptr] <= r_zero_push ? '0 : i_pe_result;
                r_fifo_last[r_wr_ptr] <= r_zero_push | r_pend_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

`ifdef PE_SCHED_PERF_EN
    logic [31:0] r_perf_busy;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (w_cmd_acc && (i_cmd_len == '0) && (i_cmd_mode == ModeIll)) begin
            r_perf_busy  <= '0;
            r_perf_stall <= '0;
        end else if (r_state == StRun) begin
            if (r_perf_busy != '1) begin
                r_perf_busy <= r_perf_busy + 32'd1;
            end
            if (!w_fire && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_busy  = r_perf_busy;
    assign o_perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_pe_dot_sched.sv
// Directed bench for pe_dot_sched with a behavioural 1-cycle MAC/EWM/EWA PE attached.
module tb_pe_dot_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_mode = 2'b00;
    logic [15:0] cmd_len = 16'd0;
    logic        cmd_err;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_b = 16'd0;
    logic        pe_valid;
    logic [1:0]  pe_mode;
    logic [15:0] pe_a;
    logic [15:0] pe_b;
    logic [31:0] pe_acc;
    logic [31:0] pe_result;
    logic        pe_valid_out;
    logic        res_valid;
    logic        res_ready = 1'b1;
    logic [31:0] res_data;
    logic        res_last;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int beats = 0;
    int last_beat_cyc = 0;
    logic [31:0] res_q [$];
    bit          last_q [$];
    int          rcyc_q [$];

    pe_dot_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_mode     (cmd_mode),
        .i_cmd_len      (cmd_len),
        .o_cmd_err      (cmd_err),
        .i_op_valid     (op_valid),
        .o_op_ready     (op_ready),
        .i_op_a         (op_a),
        .i_op_b         (op_b),
        .o_pe_valid     (pe_valid),
        .o_pe_mode      (pe_mode),
        .o_pe_a         (pe_a),
        .o_pe_b         (pe_b),
        .o_pe_acc       (pe_acc),
        .i_pe_result    (pe_result),
        .i_pe_valid_out (pe_valid_out),
        .o_res_valid    (res_valid),
        .i_res_ready    (res_ready),
        .o_res_data     (res_data),
        .o_res_last     (res_last)
    );

    always #5 clk = ~clk;

    // Reference PE: Q8.8 x Q8.8 -> Q16.16; EWA sum is shifted up to Q16.16.
    logic signed [31:0] pe_prod;
    logic signed [31:0] pe_sum;
    assign pe_prod = $signed({{16{pe_a[15]}}, pe_a}) * $signed({{16{pe_b[15]}}, pe_b});
    assign pe_sum  = ($signed({{16{pe_a[15]}}, pe_a}) + $signed({{16{pe_b[15]}}, pe_b})) <<< 8;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pe_result    <= 32'd0;
            pe_valid_out <= 1'b0;
        end else begin
            pe_valid_out <= pe_valid;
            if (pe_valid) begin
                case (pe_mode)
                    2'b00:   pe_result <= pe_acc + pe_prod;
                    2'b01:   pe_result <= pe_prod;
                    default: pe_result <= pe_sum;
                endcase
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (res_valid && res_ready) begin
                res_q.push_back(res_data);
                last_q.push_back(res_last);
                rcyc_q.push_back(cyc);
            end
            if (pe_valid) begin
                beats = beats + 1;
                last_beat_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        res_q.delete();
        last_q.delete();
        rcyc_q.delete();
        beats = 0;
    endtask

    task automatic send_cmd(input logic [1:0] m, input logic [15:0] l);
        int k;
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_len   = l;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cmd_ready && k < 50);
        if (!cmd_ready) begin
            bad++;
            $display("FAIL cmd_accept_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        total++;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic drive_ops(input int n, input logic [15:0] a [8], input logic [15:0] b [8],
                             input int gap);
        int k;
        for (int i = 0; i < n; i++) begin
            op_valid = 1'b1;
            op_a = a[i];
            op_b = b[i];
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (!op_ready && k < 50);
            if (!op_ready) begin
                bad++;
                total++;
                $display("FAIL op_ready_timeout: beat %0d op_ready=%b required 1", i, op_ready);
                op_valid = 1'b0;
                return;
            end
            tick();
            op_valid = 1'b0;
            repeat (gap) tick();
        end
    endtask

    task automatic wait_results(input int n);
        int k = 0;
        while (res_q.size() < n && k < 50) begin
            tick();
            k++;
        end
        if (res_q.size() < n) begin
            bad++;
            $display("FAIL result_timeout: got %0d results required %0d", res_q.size(), n);
        end
        total++;
    endtask

    task automatic test_reset();
        #2;
        if (cmd_ready !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0 || pe_valid !== 1'b0
            || cmd_err !== 1'b0 || res_last !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctrl: rdy=%b op=%b rv=%b pv=%b err=%b last=%b required all 0",
                     cmd_ready, op_ready, res_valid, pe_valid, cmd_err, res_last);
        end
        total++;
        if (pe_mode !== 2'b00 || pe_a !== 16'd0 || pe_b !== 16'd0 || pe_acc !== 32'd0
            || res_data !== 32'd0) begin
            bad++;
            $display("FAIL reset_data: mode=%h a=%h b=%h acc=%h res=%h required 0",
                     pe_mode, pe_a, pe_b, pe_acc, res_data);
        end
        total++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL idle_cmd_ready: got %b required 1", cmd_ready);
        end
        total++;
        tick();
    endtask

    task automatic test_mac();
        logic [15:0] a [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0};
        logic [15:0] b [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0, 0};
        clear_log();
        res_ready = 1'b1;
        send_cmd(2'b00, 16'd4);
        drive_ops(4, a, b, 0);
        wait_results(1);
        repeat (3) tick();
        if (res_q.size() != 1 || res_q[0] !== 32'h000A0000 || last_q[0] !== 1'b1) begin
            bad++;
            $display("FAIL mac4_result: n=%0d data=%h last=%b required n=1 000a0000 last=1",
                     res_q.size(), res_q.size() ? res_q[0] : 32'hx,
                     last_q.size() ? last_q[0] : 1'b0);
        end
        total++;
        if (res_q.size() > 0 && rcyc_q[0] - last_beat_cyc != 2) begin
            bad++;
            $display("FAIL mac4_latency: got %0d cycles required 2", rcyc_q[0] - last_beat_cyc);
        end
        total++;
        if (beats != 4) begin
            bad++;
            $display("FAIL mac4_beats: got %0d required 4", beats);
        end
        total++;
    endtask

    task automatic test_ewa();
        logic [15:0] a [8] = '{16'h0100, 16'hFF00, 16'h0080, 0, 0, 0, 0, 0};
        logic [31:0] exp [3] = '{32'h00020000, 32'hFFFE0000, 32'h00010000};
        clear_log();
        send_cmd(2'b10, 16'd3);
        drive_ops(3, a, a, 0);
        wait_results(3);
        for (int i = 0; i < 3; i++) begin
            if (i < res_q.size()) begin
                if (res_q[i] !== exp[i] || last_q[i] !== (i == 2)) begin
                    bad++;
                    $display("FAIL ewa_result%0d: data=%h last=%b required %h last=%b",
                             i, res_q[i], last_q[i], exp[i], (i == 2));
                end
                total++;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] a [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500, 0, 0, 0};
        logic [15:0] b [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0};
        clear_log();
        res_ready = 1'b0;
        send_cmd(2'b01, 16'd5);
        fork
            drive_ops(5, a, b, 0);
            begin
                repeat (10) @(negedge clk);
                if (beats != 2 || op_ready !== 1'b0 || res_valid !== 1'b1) begin
                    bad++;
                    $display("FAIL ewm_stall: beats=%0d op_ready=%b res_valid=%b required 2 0 1",
                             beats, op_ready, res_valid);
                end
                total++;
                tick();
                res_ready = 1'b1;
            end
        join
        wait_results(5);
        repeat (4) tick();
        if (res_q.size() != 5) begin
            bad++;
            $display("FAIL ewm_count: got %0d results required 5", res_q.size());
        end
        total++;
        for (int i = 0; i < 5 && i < res_q.size(); i++) begin
            if (res_q[i] !== {16'(i + 1), 16'h0000} || last_q[i] !== (i == 4)) begin
                bad++;
                $display("FAIL ewm_result%0d: data=%h last=%b required %h last=%b",
                         i, res_q[i], last_q[i], {16'(i + 1), 16'h0000}, (i == 4));
            end
            total++;
        end
    endtask

    task automatic test_mac_gaps();
        logic [15:0] a [8] = '{16'h0200, 16'h0200, 16'h0200, 0, 0, 0, 0, 0};
        clear_log();
        send_cmd(2'b00, 16'd3);
        drive_ops(3, a, a, 2);
        wait_results(1);
        if (res_q.size() < 1 || res_q[0] !== 32'h000C0000 || last_q[0] !== 1'b1) begin
            bad++;
            $display("FAIL mac_gap_result: data=%h required 000c0000 last=1",
                     res_q.size() ? res_q[0] : 32'hx);
        end
        total++;
    endtask

    task automatic test_illegal_and_zero();
        int opr = 0;
        clear_log();
        send_cmd(2'b11, 16'd5);
        @(negedge clk);
        if (cmd_err !== 1'b1) begin
            bad++;
            $display("FAIL cmd_err_pulse: got %b required 1", cmd_err);
        end
        total++;
        for (int i = 0; i < 4; i++) begin
            tick();
            @(negedge clk);
            if (op_ready) opr++;
        end
        if (cmd_err !== 1'b0 || opr != 0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL illegal_idle: err=%b op_ready_cycles=%0d cmd_ready=%b required 0 0 1",
                     cmd_err, opr, cmd_ready);
        end
        total++;
        tick();
        send_cmd(2'b01, 16'd0);
        repeat (5) tick();
        if (res_q.size() != 0) begin
            bad++;
            $display("FAIL ewm_len0: got %0d results required 0", res_q.size());
        end
        total++;
        send_cmd(2'b00, 16'd0);
        wait_results(1);
        if (res_q.size() < 1 || res_q[0] !== 32'd0 || last_q[0] !== 1'b1) begin
            bad++;
            $display("FAIL mac_len0: data=%h last=%b required 0 last=1",
                     res_q.size() ? res_q[0] : 32'hx, last_q.size() ? last_q[0] : 1'b0);
        end
        total++;
    endtask

    task automatic test_zero_full();
        clear_log();
        res_ready = 1'b0;
        send_cmd(2'b00, 16'd0);
        send_cmd(2'b00, 16'd0);
        tick();
        cmd_valid = 1'b1;
        cmd_mode  = 2'b00;
        cmd_len   = 16'd0;
        @(negedge clk);
        if (cmd_ready !== 1'b0) begin
            bad++;
            $display("FAIL zero_full_ready: got %b required 0", cmd_ready);
        end
        total++;
        tick();
        res_ready = 1'b1;
        @(negedge clk);
        tick();
        cmd_valid = 1'b0;
        wait_results(3);
        repeat (3) tick();
        if (res_q.size() != 3) begin
            bad++;
            $display("FAIL zero_full_count: got %0d results required 3", res_q.size());
        end
        total++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] a1 [8] = '{16'h0100, 16'h0200, 0, 0, 0, 0, 0, 0};
        logic [15:0] b1 [8] = '{16'h0100, 16'h0100, 0, 0, 0, 0, 0, 0};
        logic [15:0] a2 [8] = '{16'h0200, 0, 0, 0, 0, 0, 0, 0};
        logic [15:0] b2 [8] = '{16'h0300, 0, 0, 0, 0, 0, 0, 0};
        clear_log();
        send_cmd(2'b00, 16'd2);
        drive_ops(2, a1, b1, 0);
        send_cmd(2'b01, 16'd1);
        drive_ops(1, a2, b2, 0);
        wait_results(2);
        if (res_q.size() < 2 || res_q[0] !== 32'h00030000 || res_q[1] !== 32'h00060000
            || last_q[0] !== 1'b1 || last_q[1] !== 1'b1) begin
            bad++;
            $display("FAIL back_to_back: r0=%h r1=%h required 00030000 00060000 both last",
                     res_q.size() > 0 ? res_q[0] : 32'hx, res_q.size() > 1 ? res_q[1] : 32'hx);
        end
        total++;
    endtask

    task automatic test_mid_reset();
        logic [15:0] a [8] = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 0, 0, 0, 0};
        logic [15:0] b [8] = '{16'h0100, 16'h0100, 16'h0100, 16'h0100, 0, 0, 0, 0};
        logic [15:0] c [8] = '{16'h0100, 0, 0, 0, 0, 0, 0, 0};
        clear_log();
        res_ready = 1'b0;
        send_cmd(2'b01, 16'd4);
        drive_ops(2, a, b, 0);
        rst_n = 1'b0;
        #1;
        if (cmd_ready !== 1'b0 || op_ready !== 1'b0 || res_valid !== 1'b0 || pe_valid !== 1'b0
            || res_data !== 32'd0 || res_last !== 1'b0 || pe_mode !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset_outputs: rdy=%b op=%b rv=%b pv=%b res=%h last=%b mode=%h",
                     cmd_ready, op_ready, res_valid, pe_valid, res_data, res_last, pe_mode);
        end
        total++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        clear_log();
        repeat (4) tick();
        if (res_q.size() != 0 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_flush: got %0d results res_valid=%b required 0 0",
                     res_q.size(), res_valid);
        end
        total++;
        send_cmd(2'b10, 16'd1);
        drive_ops(1, c, c, 0);
        wait_results(1);
        if (res_q.size() < 1 || res_q[0] !== 32'h00020000 || last_q[0] !== 1'b1) begin
            bad++;
            $display("FAIL post_reset_cmd: data=%h required 00020000 last=1",
                     res_q.size() ? res_q[0] : 32'hx);
        end
        total++;
    endtask

    initial begin
        test_reset();
        test_mac();
        test_ewa();
        test_backpressure();
        test_mac_gaps();
        test_illegal_and_zero();
        test_zero_full();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pe_dot_sched.md
# pe_dot_sched

Command-driven sequencer for a single pipelined PE (MAC/EWM/EWA, 1-cycle latency, no internal accumulation). Accepts an operation command plus a length, streams operand pairs into the PE, and closes the accumulation loop for MAC by feeding the PE's registered result back as its `acc_in`. Collects PE results into a 2-entry output FIFO with ready/valid backpressure. Sits between the operand fetch logic and the downstream writeback stage of the Mamba datapath.

## Interface
- `DATA_WIDTH`, 16: operand width (Q8.8).
- `ACC_WIDTH`, 32: result width (Q16.16).
- `LEN_WIDTH`, 16: command length field width.
- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: command accepted when both high.
- `cmd_mode` in 2: 00 MAC, 01 EWM, 10 EWA, 11 illegal.
- `cmd_len` in LEN_WIDTH: number of operand pairs.
- `cmd_err` out 1: one-cycle pulse on illegal-mode command.
- `op_valid`, `op_ready` in/out 1: operand handshake.
- `op_a`, `op_b` in DATA_WIDTH: signed operands.
- `pe_valid` out 1: to PE `valid_in`.
- `pe_mode` out 2: to PE `mode`.
- `pe_a`, `pe_b` out DATA_WIDTH: to PE.
- `pe_acc` out ACC_WIDTH: to PE `acc_in`.
- `pe_result` in ACC_WIDTH: from PE `result_out`.
- `pe_valid_out` in 1: from PE `valid_out`.
- `res_valid`, `res_ready` out/in 1: result handshake.
- `res_data` out ACC_WIDTH: result.
- `res_last` out 1: final result of a command.

## Operation
- States: IDLE, RUN.
- IDLE: `cmd_ready`=1. On accept, latch mode and len, clear beat counter.
  - mode 11: pulse `cmd_err` next cycle, stay IDLE, no operands consumed.
  - len 0, MAC: push single result 0 with `res_last`=1 (subject to FIFO space; `cmd_ready`=0 while FIFO full), stay IDLE.
  - len 0, EWM/EWA: no output, stay IDLE.
  - otherwise go to RUN.
- RUN: `cmd_ready`=0. `op_ready`=1 when credit available. Beat fires on `op_valid & op_ready`.
  - `pe_valid` = beat fire; `pe_a`/`pe_b` = `op_a`/`op_b` combinationally; `pe_mode` = latched mode.
  - MAC: `pe_acc` = 0 on beat 0, `pe_result` on later beats (PE holds result across operand gaps). Only the final beat's result is pushed, with `res_last`=1.
  - EWM/EWA: `pe_acc`=0; every beat's result is pushed; `res_last`=1 on final beat only.
  - After the final beat fires, return to IDLE next cycle.
- Credit: registered `pend_push` set on a beat whose result will be pushed. Credit = `fifo_count + pend_push < 2` for pushing beats; MAC non-final beats need no credit.
- Push into FIFO when `pe_valid_out & pend_push`; `res_last` stored per entry.
- FIFO: 2 entries, in-order; simultaneous push and pop when full is legal (count unchanged).
- Mode-dependent arithmetic is entirely in the PE; no width conversion is performed here.

## Timing
- Reset values: `cmd_ready`=0 during reset, 1 in IDLE after reset; `op_ready`, `pe_valid`, `cmd_err`, `res_valid`, `res_last`=0; `pe_mode`, `pe_a`, `pe_b`, `pe_acc`, `res_data`=0. State IDLE, FIFO empty, `pend_push`=0.
- Beat at cycle t → PE result at t+1 → FIFO write at end of t+1 → `res_valid` at t+2 with `res_ready` high. Latency is 2 cycles from the final beat to the result.
- Full throughput: 1 beat/cycle in MAC; 1 beat/cycle in EWM/EWA while `res_ready`=1.
- One-cycle bubble between commands (RUN→IDLE→accept).
- A new command may start while the previous result is still in flight; ordering is preserved.
- `rst_n` low mid-command: immediate abort, FIFO flushed, no partial result emitted.

## Configuration
- `PE_SCHED_PERF_EN` defined: adds outputs `perf_busy` (32 bit, counts cycles in RUN) and `perf_stall` (32 bit, counts RUN cycles with no beat fired). Both reset to 0, saturate at all-ones, and clear on accepted command when `cmd_len`=0 and `cmd_mode`=11.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- MAC len 4, a={1.0,2.0,3.0,4.0}, b=1.0 each (Q8.8 0x0100), back-to-back → single result 0x000A0000 with `res_last`=1, 2 cycles after beat 4.
- EWA len 3, a=b={0x0100,0xFF00,0x0080} → results 0x00020000, 0xFFFE0000, 0x00010000 in order; `res_last` on the third only.
- EWM len 5, `res_ready` held 0 → `op_ready` drops after 2 beats; release → remaining 3 results, none lost or duplicated.
- MAC len 3 with `op_valid` gaps of 2 cycles between beats, a=b=0x0200 → result 0x000C0000; `perf_stall`=4 when the macro is defined.
- mode 11 → `cmd_err` pulse, no `op_ready`. MAC len 0 → single 0 result, `res_last`=1.
- Reset asserted 1 cycle after the second beat of an EWM len 4 → all outputs at reset values, FIFO empty; a new command then runs correctly.
